// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state enum, parameter defaults and 8N1 frame constants
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int OVERSAMPLE_DEFAULT = 8;
    localparam int DATA_BITS_DEFAULT = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam int STOP_BITS = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS_DEFAULT + STOP_BITS;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: two-flop synchronizer for an asynchronous input pin
module bit_synchronizer #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, meta} <= {2{RESET_VAL}};
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with valid/ready output and error pulses
module uart_rx import uart_pkg::*; #(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [TW-1:0]        tick_cnt, tick_n;
    logic [BW-1:0]        bit_idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic                 armed, armed_n, valid_n, ferr_n, oerr_n;

    bit_synchronizer #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_serial),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            bit_idx     <= idx_n;
            shreg       <= shreg_n;
            armed       <= armed_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_err   <= ferr_n;
            overrun_err <= oerr_n;
            busy        <= state_n != IDLE;
        end
    end

    // armed re-qualifies only after an idle-high tick, so a stuck-low line cannot retrigger
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        idx_n   = bit_idx;
        shreg_n = shreg;
        armed_n = armed;
        data_n  = rx_data;
        valid_n = rx_valid && !rx_ready;
        ferr_n  = 1'b0;
        oerr_n  = 1'b0;
        if (baud_tick && rx_s) armed_n = 1'b1;
        if (baud_tick) begin
            case (state)
                IDLE: if (rx_s == START_BIT && armed) begin
                    state_n = START;
                    tick_n  = '0;
                end
                START: if (tick_cnt == HALF_TICK) begin
                    state_n = rx_s ? IDLE : DATA;
                    tick_n  = '0;
                    idx_n   = '0;
                end else tick_n = tick_cnt + 1'b1;
                DATA: if (tick_cnt == LAST_TICK) begin
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    idx_n   = bit_idx + 1'b1;
                    tick_n  = '0;
                    state_n = bit_idx == LAST_BIT ? STOP : DATA;
                end else tick_n = tick_cnt + 1'b1;
                STOP: if (tick_cnt == LAST_TICK) begin
                    state_n = IDLE;
                    tick_n  = '0;
                    armed_n = 1'b0;
                    if (rx_s == STOP_BIT) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        oerr_n  = rx_valid && !rx_ready;
                    end else ferr_n = 1'b1;
                end else tick_n = tick_cnt + 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
